vliw_regfile: RTL

Shared integer register file for the four-lane STARBUG VLIW core. It serves the relayed register-file ports of the four per-lane integer datapaths: each lane's Decode stage gets two read ports, and each lane's Writeback stage gets one write port. Same-cycle writes are bypassed to same-cycle reads, so Decode always sees the value committed in Writeback that cycle. Multi-lane writes to the same register are arbitrated deterministically, and each collision is flagged and counted for the hazard unit and for debug.

---
 rtl/vliw_regfile_pkg.sv | 27 ++
 rtl/vliw_wrarb.sv | 37 +++
 rtl/vliw_regfile.sv | 121 ++++++++++++
 3 files changed

// File: rtl/vliw_regfile_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vliw_regfile_pkg
//  Description : Shared constants, types and helpers for the four-lane
//                STARBUG VLIW integer register file.
//  Revision    : 1.0 - initial release
// ============================================================================
package vliw_regfile_pkg;

    // Number of issue lanes in a bundle
    localparam int VLIW_LANES = 4;

    // Architectural register name space (x0..x31)
    localparam int REG_COUNT = 32;

    typedef logic [4:0]                  regaddr_t;
    typedef regaddr_t [VLIW_LANES-1:0]   lane_addr_t;
    typedef logic [VLIW_LANES-1:0]       lane_mask_t;

    // In the reduced (E) register set the upper half of the name space
    // aliases onto x0..x15, so bit 4 of every address is dropped.
    function automatic regaddr_t mask_addr(input regaddr_t addr, input bit e_mode);
        return e_mode ? {1'b0, addr[3:0]} : addr;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vliw_wrarb.sv
`default_nettype none
// ============================================================================
//  Module      : vliw_wrarb
//  Description : Combinational write arbiter. Picks the effective write per
//                lane (highest lane wins a same-register collision) and flags
//                the lanes whose write is suppressed.
//  Revision    : 1.0 - initial release
// ============================================================================
module vliw_wrarb
    import vliw_regfile_pkg::*;
(
    input  logic [VLIW_LANES-1:0] we3,
    input  lane_addr_t            a3,
    output logic [VLIW_LANES-1:0] eff,
    output logic [VLIW_LANES-1:0] mask
);

    for (genvar l = 0; l < VLIW_LANES; l++) begin : g_lane
        logic shadowed;

        // A lane is shadowed when any later lane in the bundle writes the same register
        always_comb begin
            shadowed = 1'b0;
            for (int m = l + 1; m < VLIW_LANES; m++) begin
                if (we3[m] && (a3[m] == a3[l])) begin
                    shadowed = 1'b1;
                end
            end
        end

        // x0 writes are discarded outright, so they neither win nor collide
        assign eff[l]  = we3[l] && (a3[l] != 5'd0) && !shadowed;
        assign mask[l] = we3[l] && (a3[l] != 5'd0) &&  shadowed;
    end

endmodule
`default_nettype wire

// File: rtl/vliw_regfile.sv
`default_nettype none
// ============================================================================
//  Module      : vliw_regfile
//  Description : Shared integer register file for the four-lane STARBUG VLIW
//                core. 8 read ports, 4 write ports, same-cycle write-to-read
//                bypass, deterministic collision arbitration and a saturating
//                collision counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module vliw_regfile
    import vliw_regfile_pkg::*;
#(
    parameter int XLEN        = 64,
    parameter bit E_SUPPORTED = 1'b0,
    parameter int CNTW        = 16
)(
    input  logic                             clk,
    input  logic                             reset,
    input  logic [VLIW_LANES-1:0]            we3,
    input  lane_addr_t                       a1,
    input  lane_addr_t                       a2,
    input  lane_addr_t                       a3,
    input  logic [VLIW_LANES-1:0][XLEN-1:0]  wd3,
    output logic [VLIW_LANES-1:0][XLEN-1:0]  rd1,
    output logic [VLIW_LANES-1:0][XLEN-1:0]  rd2,
    input  logic                             ClearCount,
    output logic                             CollisionW,
    output logic [VLIW_LANES-1:0]            CollisionMask,
    output logic [CNTW-1:0]                  CollisionCount
);

    // Physically stored registers (x0 has no storage)
    localparam int NREGS = E_SUPPORTED ? 15 : 31;

    lane_addr_t                   a1_m;
    lane_addr_t                   a2_m;
    lane_addr_t                   a3_m;
    logic [VLIW_LANES-1:0]        eff;
    logic [XLEN-1:0]              regs    [1:NREGS];
    logic [REG_COUNT-1:0]         wr_hit;
    logic [XLEN-1:0]              wr_data [REG_COUNT];
    logic [XLEN-1:0]              stored  [REG_COUNT];

    // Fold addresses into the implemented register set
    always_comb begin
        for (int l = 0; l < VLIW_LANES; l++) begin
            a1_m[l] = mask_addr(a1[l], E_SUPPORTED);
            a2_m[l] = mask_addr(a2[l], E_SUPPORTED);
            a3_m[l] = mask_addr(a3[l], E_SUPPORTED);
        end
    end

    vliw_wrarb u_wrarb (
        .we3  (we3),
        .a3   (a3_m),
        .eff  (eff),
        .mask (CollisionMask)
    );

    assign CollisionW = |CollisionMask;

    // Per-register write decode; effective writes are unique per register,
    // so the same table drives both storage update and read bypass.
    always_comb begin
        wr_hit = '0;
        for (int r = 0; r < REG_COUNT; r++) begin
            wr_data[r] = '0;
        end
        for (int l = 0; l < VLIW_LANES; l++) begin
            if (eff[l]) begin
                wr_hit[a3_m[l]]  = 1'b1;
                wr_data[a3_m[l]] = wd3[l];
            end
        end
    end

    // Full 32-entry view of storage: x0 and unimplemented registers read 0
    for (genvar r = 0; r < REG_COUNT; r++) begin : g_view
        if (r >= 1 && r <= NREGS) begin : g_live
            assign stored[r] = regs[r];
        end else begin : g_zero
            assign stored[r] = '0;
        end
    end

    // Storage array: all effective writes commit together on the rising edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int r = 1; r <= NREGS; r++) begin
                regs[r] <= '0;
            end
        end else begin
            for (int r = 1; r <= NREGS; r++) begin
                if (wr_hit[r]) begin
                    regs[r] <= wr_data[r];
                end
            end
        end
    end

    // Read ports: same-cycle winning write data takes precedence over storage
    always_comb begin
        for (int l = 0; l < VLIW_LANES; l++) begin
            rd1[l] = wr_hit[a1_m[l]] ? wr_data[a1_m[l]] : stored[a1_m[l]];
            rd2[l] = wr_hit[a2_m[l]] ? wr_data[a2_m[l]] : stored[a2_m[l]];
        end
    end

    // Saturating collision counter; clear wins over increment
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            CollisionCount <= '0;
        end else if (ClearCount) begin
            CollisionCount <= '0;
        end else if (CollisionW && !(&CollisionCount)) begin
            CollisionCount <= CollisionCount + CNTW'(1);
        end
    end

endmodule
`default_nettype wire
